// File: rtl/csr_access_ctrl.sv
// Sequencer that owns the CSR file port: runs Zicsr read-modify-write ops and
// machine-trap entry (mepc/mcause writes, then hands back the mtvec target).
module csr_access_ctrl #(
  parameter int WORD_LEN = 32,
  parameter int REG_ADDR_SIZE = 12,
  parameter logic [REG_ADDR_SIZE-1:0] MEPC_ADDR = 12'h341,
  parameter logic [REG_ADDR_SIZE-1:0] MCAUSE_ADDR = 12'h342
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [REG_ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_LEN-1:0]      req_operand,
  output logic                     resp_valid,
  output logic [WORD_LEN-1:0]      resp_rdata,
  output logic                     resp_err,
  input  logic                     trap_valid,
  input  logic [WORD_LEN-1:0]      trap_pc,
  input  logic [WORD_LEN-1:0]      trap_cause,
  output logic                     trap_ack,
  output logic                     trap_done,
  output logic [WORD_LEN-1:0]      trap_target,
  output logic [REG_ADDR_SIZE-1:0] csr_addr,
  output logic                     csr_wen,
  output logic [WORD_LEN-1:0]      csr_wdata,
  input  logic [WORD_LEN-1:0]      csr_rdata,
  input  logic [WORD_LEN-1:0]      trap_vector
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] MOD    = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RSP    = 3'd4;
  localparam logic [2:0] TEPC   = 3'd5;
  localparam logic [2:0] TCAUSE = 3'd6;
  localparam logic [2:0] TDONE  = 3'd7;

  logic [2:0]               state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic                     ro_q, ro_d;
  logic [WORD_LEN-1:0]      operand_q, operand_d;
  logic [WORD_LEN-1:0]      cause_q, cause_d;
  logic [WORD_LEN-1:0]      old_q, old_d;
  logic                     err_q, err_d;
  logic [REG_ADDR_SIZE-1:0] csr_addr_q, csr_addr_d;
  logic                     csr_wen_q, csr_wen_d;
  logic [WORD_LEN-1:0]      csr_wdata_q, csr_wdata_d;

  logic                     op_legal;
  logic                     wants_write;
  logic                     err_c;
  logic                     wen_c;
  logic [WORD_LEN-1:0]      new_c;

  // Set/clear with a zero operand is a pure read and must not touch the CSR.
  always_comb begin
    op_legal    = !(op_q inside {3'd0, 3'd4});
    wants_write = op_legal && ((op_q[1:0] == 2'b01) || (operand_q != '0));
    err_c       = !op_legal || (ro_q && wants_write);
    wen_c       = wants_write && !ro_q;
    case (op_q[1:0])
      2'b10:   new_c = csr_rdata | operand_q;
      2'b11:   new_c = csr_rdata & ~operand_q;
      default: new_c = operand_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ro_d        = ro_q;
    operand_d   = operand_q;
    cause_d     = cause_q;
    old_d       = old_q;
    err_d       = err_q;
    csr_addr_d  = csr_addr_q;
    csr_wen_d   = csr_wen_q;
    csr_wdata_d = csr_wdata_q;
    case (state_q)
      IDLE: begin
        if (trap_valid) begin
          state_d     = TEPC;
          cause_d     = trap_cause;
          csr_addr_d  = MEPC_ADDR;
          csr_wen_d   = 1'b1;
          csr_wdata_d = trap_pc;
        end else if (req_valid) begin
          state_d    = RD;
          op_d       = req_op;
          ro_d       = (req_addr[REG_ADDR_SIZE-1 -: 2] == 2'b11);
          operand_d  = req_operand;
          csr_addr_d = req_addr;
        end
      end
      RD:  state_d = MOD;
      MOD: begin
        state_d = WR;
        old_d   = csr_rdata;
        err_d   = err_c;
        if (wen_c) begin
          csr_wen_d   = 1'b1;
          csr_wdata_d = new_c;
        end
      end
      WR: begin
        state_d   = RSP;
        csr_wen_d = 1'b0;
      end
      RSP:  state_d = IDLE;
      TEPC: begin
        state_d     = TCAUSE;
        csr_addr_d  = MCAUSE_ADDR;
        csr_wdata_d = cause_q;
      end
      TCAUSE: begin
        state_d   = TDONE;
        csr_wen_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      ro_q        <= 1'b0;
      operand_q   <= '0;
      cause_q     <= '0;
      old_q       <= '0;
      err_q       <= 1'b0;
      csr_addr_q  <= '0;
      csr_wen_q   <= 1'b0;
      csr_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ro_q        <= ro_d;
      operand_q   <= operand_d;
      cause_q     <= cause_d;
      old_q       <= old_d;
      err_q       <= err_d;
      csr_addr_q  <= csr_addr_d;
      csr_wen_q   <= csr_wen_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  // Handshake outputs are gated by rst_n so everything reads 0 while in reset.
  assign req_ready   = rst_n && (state_q == IDLE) && !trap_valid;
  assign trap_ack    = rst_n && (state_q == IDLE) && trap_valid;
  assign resp_valid  = (state_q == RSP);
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = (resp_valid && !err_q) ? old_q : '0;
  assign trap_done   = (state_q == TDONE);
  assign trap_target = trap_done ? (trap_vector & ~{{(WORD_LEN-2){1'b0}}, 2'b11}) : '0;
  assign csr_addr    = csr_addr_q;
  assign csr_wen     = csr_wen_q;
  assign csr_wdata   = csr_wdata_q;

endmodule
